// File: rtl/iob_eth_rx_fq_pkg.sv
// iob_eth_rx_fq_pkg: shared types and geometry helpers for the RX frame queue.
// Holds the write-FSM state encoding and default slot geometry.
package iob_eth_rx_fq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } wr_st_t;

  localparam int DEF_SLOT_ADDR_W = 11;
  localparam int DEF_N_SLOTS_W   = 2;

  function automatic int n_slots(input int n_slots_w);
    return 1 << n_slots_w;
  endfunction

  function automatic int max_len(input int slot_addr_w);
    return (1 << slot_addr_w) - 1;
  endfunction

endpackage

// File: rtl/iob_eth_rx_fq_ram.sv
// iob_eth_rx_fq_ram: single-clock simple dual-port frame RAM.
// Ports: i_we/i_waddr/i_wdata write; i_raddr -> o_rdata registered, cleared by rst_int/i_clr.
module iob_eth_rx_fq_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_int,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int)    r_rdata <= '0;
    else if (i_clr) r_rdata <= '0;
    else            r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/iob_eth_rx_frame_queue.sv
// iob_eth_rx_frame_queue: ring of 2^N_SLOTS_W RX frame slots fed by a byte stream.
// In: in_valid/in_data/in_last/in_err stream, flush, pop, rd_addr.
// Out: rd_data (1-cycle), head_valid/len/err, occupancy, drop_cnt.
// Optional IOB_ETH_RX_FQ_STATS_EN adds rx_frames/rx_bytes counters.
module iob_eth_rx_frame_queue
  import iob_eth_rx_fq_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SLOT_ADDR_W = DEF_SLOT_ADDR_W,
  parameter int N_SLOTS_W   = DEF_N_SLOTS_W,
  parameter int DROP_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_int,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_last,
  input  logic                   in_err,
  input  logic [SLOT_ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   head_valid,
  output logic [SLOT_ADDR_W-1:0] head_len,
  output logic                   head_err,
  input  logic                   pop,
  output logic [N_SLOTS_W:0]     occupancy,
  output logic [DROP_CNT_W-1:0]  drop_cnt
`ifdef IOB_ETH_RX_FQ_STATS_EN
  ,
  output logic [31:0]            rx_frames,
  output logic [31:0]            rx_bytes
`endif
);

  localparam int N_SLOTS = n_slots(N_SLOTS_W);
  localparam logic [SLOT_ADDR_W-1:0] CNT_MAX = SLOT_ADDR_W'(max_len(SLOT_ADDR_W));
  localparam logic [SLOT_ADDR_W-1:0] CNT_ONE = SLOT_ADDR_W'(1);
  localparam logic [N_SLOTS_W:0]     OCC_MAX = (N_SLOTS_W+1)'(N_SLOTS);
  localparam logic [N_SLOTS_W:0]     OCC_ONE = (N_SLOTS_W+1)'(1);
  localparam logic [N_SLOTS_W-1:0]   PTR_ONE = N_SLOTS_W'(1);

  wr_st_t                 r_st, w_nxt_st;
  logic [SLOT_ADDR_W-1:0] r_cnt, w_nxt_cnt, w_wbyte;
  logic [N_SLOTS_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [N_SLOTS_W:0]     r_occ;
  logic [DROP_CNT_W-1:0]  r_drop;
  logic [SLOT_ADDR_W-1:0] r_len [N_SLOTS];
  logic [N_SLOTS-1:0]     r_err;

  logic w_full, w_we, w_commit, w_drop_inc, w_pop, w_head_valid;

  assign w_head_valid = (r_occ != '0);
  assign w_full       = (r_occ == OCC_MAX);
  assign w_pop        = pop & w_head_valid & ~flush;

  always_comb begin
    w_nxt_st   = r_st;
    w_nxt_cnt  = r_cnt;
    w_wbyte    = r_cnt;
    w_we       = 1'b0;
    w_commit   = 1'b0;
    w_drop_inc = 1'b0;
    unique case (r_st)
      ST_IDLE: begin
        if (in_valid) begin
          if (w_full) begin
            w_drop_inc = 1'b1;
            if (!in_last) w_nxt_st = ST_DROP;
          end else begin
            w_we      = 1'b1;
            w_wbyte   = '0;
            w_nxt_cnt = CNT_ONE;
            if (in_last) w_commit = 1'b1;
            else         w_nxt_st = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (in_valid) begin
          w_we      = 1'b1;
          w_nxt_cnt = r_cnt + CNT_ONE;
          if (in_last) begin
            w_commit = 1'b1;
            w_nxt_st = ST_IDLE;
          end else if (w_nxt_cnt == CNT_MAX) begin
            w_drop_inc = 1'b1;
            w_nxt_st   = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (in_valid && in_last) w_nxt_st = ST_IDLE;
      end
      default: w_nxt_st = ST_IDLE;
    endcase
    // Flush discards whatever is in flight without counting it as a drop.
    if (flush) begin
      w_we       = 1'b0;
      w_commit   = 1'b0;
      w_drop_inc = 1'b0;
      if (in_valid && in_last)            w_nxt_st = ST_IDLE;
      else if (in_valid || r_st != ST_IDLE) w_nxt_st = ST_DROP;
      else                                w_nxt_st = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      r_st     <= ST_IDLE;
      r_cnt    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      r_st  <= w_nxt_st;
      r_cnt <= w_nxt_cnt;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_occ    <= '0;
      end else begin
        if (w_commit) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_ONE;
        if (w_commit && !w_pop)      r_occ <= r_occ + OCC_ONE;
        else if (!w_commit && w_pop) r_occ <= r_occ - OCC_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      for (int i = 0; i < N_SLOTS; i++) r_len[i] <= '0;
      r_err <= '0;
    end else if (w_commit) begin
      r_len[r_wr_ptr] <= w_nxt_cnt;
      r_err[r_wr_ptr] <= in_err;
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) r_drop <= '0;
    else if (w_drop_inc && r_drop != '1) r_drop <= r_drop + 1'b1;
  end

  iob_eth_rx_fq_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(N_SLOTS_W + SLOT_ADDR_W)
  ) u_ram (
    .clk    (clk),
    .rst_int(rst_int),
    .i_clr  (flush),
    .i_we   (w_we),
    .i_waddr({r_wr_ptr, w_wbyte}),
    .i_wdata(in_data),
    .i_raddr({r_rd_ptr, rd_addr}),
    .o_rdata(rd_data)
  );

  // Stale status of an empty ring is masked so reset/flush read as zero.
  assign head_valid = w_head_valid;
  assign head_len   = w_head_valid ? r_len[r_rd_ptr] : '0;
  assign head_err   = w_head_valid & r_err[r_rd_ptr];
  assign occupancy  = r_occ;
  assign drop_cnt   = r_drop;

`ifdef IOB_ETH_RX_FQ_STATS_EN
  logic [31:0] r_frames, r_bytes;

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      r_frames <= '0;
      r_bytes  <= '0;
    end else if (w_commit) begin
      r_frames <= r_frames + 32'd1;
      r_bytes  <= r_bytes + 32'(w_nxt_cnt);
    end
  end

  assign rx_frames = r_frames;
  assign rx_bytes  = r_bytes;
`endif

endmodule

// File: tb/tb_iob_eth_rx_frame_queue.sv
// tb_iob_eth_rx_frame_queue: directed + random bench with frame scoreboard.
// Frames are modelled as (seed, len, err); byte i of a frame is seed+i.
module tb_iob_eth_rx_frame_queue;

  typedef struct packed {
    int   seed;
    int   len;
    logic err;
  } frm_t;

  logic        clk = 1'b0;
  logic        rst_int, flush, in_valid, in_last, in_err;
  logic [7:0]  in_data;
  logic [10:0] rd_addr, main_addr, mon_addr;
  logic [7:0]  rd_data;
  logic        head_valid, head_err, pop, main_pop, mon_pop, drain_en;
  logic [10:0] head_len;
  logic [2:0]  occupancy;
  logic [15:0] drop_cnt;
`ifdef IOB_ETH_RX_FQ_STATS_EN
  logic [31:0] rx_frames, rx_bytes;
`endif

  frm_t exp_q[$];
  int   exp_drop = 0;
  int   mdl_frames = 0;
  int   mdl_bytes = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign rd_addr = drain_en ? mon_addr : main_addr;
  assign pop     = main_pop | mon_pop;

  iob_eth_rx_frame_queue dut (
    .clk       (clk),
    .rst_int   (rst_int),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_err    (in_err),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .head_valid(head_valid),
    .head_len  (head_len),
    .head_err  (head_err),
    .pop       (pop),
    .occupancy (occupancy),
    .drop_cnt  (drop_cnt)
`ifdef IOB_ETH_RX_FQ_STATS_EN
    ,
    .rx_frames (rx_frames),
    .rx_bytes  (rx_bytes)
`endif
  );

  function automatic logic [7:0] eb(input int seed, input int i);
    return 8'(seed + i);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Drives one frame; model decides commit/drop from queue size at frame start.
  task automatic send_frame(input int seed, input int len, input logic err,
                            input int gap, input bit pop_last, input int flush_at);
    bit drop, flushed;
    drop    = (exp_q.size() == 4);
    flushed = 0;
    if (drop) exp_drop++;
    for (int i = 0; i < len; i++) begin
      if (i > 0 && gap > 0 && $urandom_range(3, 0) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(gap, 1)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = eb(seed, i);
      in_last  = (i == len - 1);
      in_err   = in_last ? err : 1'($urandom);
      flush    = (i == flush_at);
      if (pop_last && in_last) begin
        check("pop_last_len", 32'(head_len), 32'(exp_q[0].len));
        main_pop = 1'b1;
      end
      @(posedge clk);
      #1;
      if (flush) begin
        exp_q.delete();
        flushed = 1;
      end
      if (!drop && !flushed && !in_last && i == 2046) begin
        drop = 1;
        exp_drop++;
      end
      if (in_last) begin
        if (pop_last) void'(exp_q.pop_front());
        if (!drop && !flushed) begin
          exp_q.push_back('{seed: seed, len: len, err: err});
          mdl_frames++;
          mdl_bytes += len;
        end
      end
      @(negedge clk);
      flush    = 1'b0;
      main_pop = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_err   = 1'b0;
  endtask

  task automatic pop_head(input string nm);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s act=head exp=no_frame", nm);
      return;
    end
    check({nm, "_valid"}, 32'(head_valid), 32'd1);
    check({nm, "_len"}, 32'(head_len), 32'(exp_q[0].len));
    check({nm, "_err"}, 32'(head_err), 32'(exp_q[0].err));
    main_pop = 1'b1;
    @(posedge clk);
    #1;
    void'(exp_q.pop_front());
    @(negedge clk);
    main_pop = 1'b0;
  endtask

  task automatic read_chk(input string nm, input int a);
    main_addr = 11'(a);
    @(posedge clk);
    @(negedge clk);
    check(nm, 32'(rd_data), 32'(eb(exp_q[0].seed, a)));
  endtask

  task automatic chk_state(input string nm);
    check({nm, "_occ"}, 32'(occupancy), 32'(exp_q.size()));
    check({nm, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
  endtask

  // Monitor: drains and checks heads whenever draining is enabled.
  initial begin
    frm_t f;
    int   a;
    mon_pop  = 1'b0;
    mon_addr = '0;
    forever begin
      @(negedge clk);
      if (drain_en && head_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_head act=valid exp=empty");
        end else begin
          f = exp_q[0];
          check("mon_len", 32'(head_len), 32'(f.len));
          check("mon_err", 32'(head_err), 32'(f.err));
          for (int k = 0; k < 3; k++) begin
            a = (k == 0) ? 0 : (k == 1) ? f.len - 1 :
                int'($urandom_range(f.len - 1, 0));
            mon_addr = 11'(a);
            @(negedge clk);
            check("mon_data", 32'(rd_data), 32'(eb(f.seed, a)));
          end
          mon_pop = 1'b1;
          @(posedge clk);
          #1;
          void'(exp_q.pop_front());
          @(negedge clk);
          mon_pop = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_int   = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_err    = 1'b0;
    main_addr = '0;
    main_pop  = 1'b0;
    drain_en  = 1'b0;
    repeat (3) @(negedge clk);
    rst_int = 1'b0;
    check("rst_hv", 32'(head_valid), 32'd0);
    check("rst_len", 32'(head_len), 32'd0);
    check("rst_err", 32'(head_err), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    chk_state("rst");

    // Single 64-byte frame 0x00..0x3F
    send_frame(0, 64, 1'b0, 0, 0, -1);
    chk_state("t1");
    check("t1_hv", 32'(head_valid), 32'd1);
    check("t1_len", 32'(head_len), 32'd64);
    read_chk("t1_rd5", 5);
    pop_head("t1_pop");
    chk_state("t1_after");
    check("t1_hv0", 32'(head_valid), 32'd0);

    // Five back-to-back frames overfill the 4-slot ring
    for (int i = 1; i <= 5; i++) send_frame(i * 40, 60, 1'b0, 0, 0, -1);
    chk_state("t2");
    for (int i = 0; i < 4; i++) begin
      read_chk("t2_rd0", 0);
      pop_head("t2_pop");
    end
    chk_state("t2_after");

    // Oversize frame is dropped; a normal one follows
    send_frame(7, 2100, 1'b0, 0, 0, -1);
    chk_state("t3");
    send_frame(9, 46, 1'b0, 0, 0, -1);
    check("t3_len", 32'(head_len), 32'd46);
    pop_head("t3_pop");

    // Commit coinciding with pop at occupancy 2
    send_frame(11, 30, 1'b0, 0, 0, -1);
    send_frame(12, 40, 1'b1, 0, 0, -1);
    send_frame(13, 50, 1'b0, 0, 1, -1);
    chk_state("t4");
    check("t4_len", 32'(head_len), 32'd40);
    read_chk("t4_rd", 3);
    pop_head("t4_pop1");
    pop_head("t4_pop2");

    // Flush mid-frame with three frames queued
    for (int i = 0; i < 3; i++) send_frame(20 + i, 25, 1'b0, 0, 0, -1);
    send_frame(30, 50, 1'b0, 0, 0, 30);
    chk_state("t5");
    check("t5_hv", 32'(head_valid), 32'd0);
    send_frame(33, 20, 1'b0, 0, 0, -1);
    check("t5_len", 32'(head_len), 32'd20);
    read_chk("t5_rd", 3);
    pop_head("t5_pop");

    // Error frame then a one-byte frame
    send_frame(40, 10, 1'b1, 0, 0, -1);
    send_frame(41, 1, 1'b0, 0, 0, -1);
    check("t6_err", 32'(head_err), 32'd1);
    pop_head("t6_pop1");
    check("t6_len1", 32'(head_len), 32'd1);
    read_chk("t6_rd", 0);
    pop_head("t6_pop2");

    // Random traffic with concurrent draining
    drain_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      int len;
      len = ($urandom_range(9, 0) == 0) ? int'($urandom_range(300, 100))
                                         : int'($urandom_range(40, 1));
      send_frame(int'($urandom_range(255, 0)), len, 1'($urandom), 2, 0, -1);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk);
    check("rnd_drained", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
    drain_en = 1'b0;
    chk_state("rnd");

`ifdef IOB_ETH_RX_FQ_STATS_EN
    check("st_frames", rx_frames, 32'(mdl_frames));
    check("st_bytes", rx_bytes, 32'(mdl_bytes));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
